// File: rtl/slow_clk_ctrl_pkg.sv
// Shared types and defaults for the slow-clock controller: FSM state encoding
// and the default counter width / half-period.
package slow_clk_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_HALF_DIV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/slow_clk_ctrl_if.sv
// Configuration / status bundle between the configuration logic (master) and
// the slow-clock controller (slave).
interface slow_clk_ctrl_if
  import slow_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_slow;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_slow, tick, busy, cur_div
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_slow, tick, busy, cur_div
  );

endinterface

// File: rtl/slow_clk_ctrl_half_period_counter.sv
// Half-period counter: owns cnt and the registered clk_slow, and flags the
// edges on which clk_slow is about to rise or fall.
module half_period_counter
  import slow_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] div,
  output logic             clk_slow,
  output logic             toggle_rise,
  output logic             toggle_fall
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_slow_q, clk_slow_d;
  logic             term;

  always_comb begin
    term        = (cnt_q == div - CNT_W'(1));
    cnt_d       = cnt_q;
    clk_slow_d  = clk_slow_q;
    toggle_rise = 1'b0;
    toggle_fall = 1'b0;
    // load restarts at the beginning of a low phase
    if (load) begin
      cnt_d      = load_val;
      clk_slow_d = 1'b0;
    end else if (run) begin
      if (term) begin
        cnt_d       = '0;
        clk_slow_d  = !clk_slow_q;
        toggle_rise = !clk_slow_q;
        toggle_fall = clk_slow_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      clk_slow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_slow_q <= clk_slow_d;
    end
  end

  assign clk_slow = clk_slow_q;

endmodule

// File: rtl/slow_clk_ctrl.sv
// Slow-clock controller: run/stop FSM, cfg handshake with a one-deep pending
// register, and glitch-free ratio switching at falling boundaries of clk_slow.
module slow_clk_ctrl
  import slow_clk_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_HALF_DIV
) (
  input logic                 clk,
  input logic                 rst,
  slow_clk_ctrl_if.slave      bus
);

  state_e           state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             run, load;
  logic             clk_slow, toggle_rise, toggle_fall;
  logic             accept, enter_idle, apply;

  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .load        (load),
    .load_val    ('0),
    .div         (cur_div_q),
    .clk_slow    (clk_slow),
    .toggle_rise (toggle_rise),
    .toggle_fall (toggle_fall)
  );

  // Counter control: a low phase may be cut short on stop, a high phase never.
  always_comb begin
    run  = 1'b0;
    load = 1'b0;
    unique case (state_q)
      IDLE: load = 1'b1;
      RUN: begin
        if (!bus.en && !clk_slow) load = 1'b1;
        else                      run  = 1'b1;
      end
      STOP:    run  = 1'b1;
      default: load = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.en) state_d = RUN;
      RUN: begin
        if (!bus.en) state_d = (!clk_slow || toggle_fall) ? IDLE : STOP;
      end
      STOP: begin
        if (bus.en)           state_d = RUN;
        else if (toggle_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A stored word is applied at the next falling boundary or once idle.
  always_comb begin
    accept     = bus.cfg_valid && !pend_vld_q;
    enter_idle = (state_q != IDLE) && (state_d == IDLE);
    apply      = pend_vld_q && (toggle_fall || enter_idle || (state_q == IDLE));
    pend_vld_d = pend_vld_q;
    pend_div_d = pend_div_q;
    cur_div_d  = cur_div_q;
    cfg_err_d  = accept && (bus.cfg_div == '0);
    tick_d     = toggle_rise;
    if (apply) begin
      cur_div_d  = pend_div_q;
      pend_vld_d = 1'b0;
    end else if (accept && (bus.cfg_div != '0)) begin
      if (state_q == IDLE) begin
        cur_div_d = bus.cfg_div;
      end else begin
        pend_div_d = bus.cfg_div;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pend_div_q <= '0;
      cur_div_q  <= CNT_W'(DEF_DIV);
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_div_q <= pend_div_d;
      cur_div_q  <= cur_div_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.cfg_ready = !pend_vld_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.clk_slow  = clk_slow;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cur_div   = cur_div_q;

endmodule

// File: tb/tb_slow_clk_ctrl.sv
// Directed + randomized bench for slow_clk_ctrl against a cycle reference model.
module tb_slow_clk_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slow_clk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  slow_clk_ctrl #(.CNT_W(CNT_W), .DEF_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0=idle 1=run 2=stopping; pos = cycles into half-phase
  int m_mode, m_pos, m_cur, m_pdiv;
  bit m_lvl, m_pvld, m_tick, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_lvl = 0; m_cur = 2;
    m_pdiv = 0; m_pvld = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int d);
    bit acc    = v && !m_pvld;
    bit old    = m_lvl;
    bit rise   = 0;
    bit fall   = 0;
    bit counting;
    int nxt    = m_mode;
    counting = (m_mode == 2) || (m_mode == 1 && (e || m_lvl));
    if (counting) begin
      if (m_pos == m_cur - 1) begin
        m_pos = 0; rise = !m_lvl; fall = m_lvl; m_lvl = !m_lvl;
      end else m_pos++;
    end else begin
      m_pos = 0; m_lvl = 0;
    end
    if (m_mode == 0 && e) nxt = 1;
    if (m_mode == 1 && !e) nxt = (!old || fall) ? 0 : 2;
    if (m_mode == 2) nxt = e ? 1 : (fall ? 0 : 2);
    if (m_pvld && (fall || m_mode == 0 || nxt == 0)) begin
      m_cur = m_pdiv; m_pvld = 0;
    end else if (acc && d != 0) begin
      if (m_mode == 0) m_cur = d;
      else begin m_pdiv = d; m_pvld = 1; end
    end
    m_tick = rise;
    m_err  = acc && (d == 0);
    m_mode = nxt;
  endtask

  task automatic check_all();
    chk("clk_slow",  {31'b0, bus.clk_slow},  {31'b0, m_lvl});
    chk("tick",      {31'b0, bus.tick},      {31'b0, m_tick});
    chk("cfg_ready", {31'b0, bus.cfg_ready}, {31'b0, !m_pvld});
    chk("cfg_err",   {31'b0, bus.cfg_err},   {31'b0, m_err});
    chk("busy",      {31'b0, bus.busy},      {31'b0, (m_mode != 0)});
    chk("cur_div",   {16'b0, bus.cur_div},   32'(m_cur));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit e, input bit v, input int d);
    bus.en = e; bus.cfg_valid = v; bus.cfg_div = CNT_W'(d);
    @(posedge clk);
    model_edge(e, v, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_rise(input bit e);
    int w = 0;
    while (!m_tick && w < 100) begin cyc(e, 0, 0); w++; end
    chk("wait_rise", {31'b0, bus.tick}, 32'd1);
  endtask

  task automatic meas(input bit lvl, input bit e, output int len);
    int w = 0;
    while (bus.clk_slow !== lvl && w < 100) begin cyc(e, 0, 0); w++; end
    len = 0;
    while (bus.clk_slow === lvl && len < 100) begin len++; cyc(e, 0, 0); end
  endtask

  initial begin
    int len, ticks, r;
    bit ren;
    bus.en = 0; bus.cfg_valid = 0; bus.cfg_div = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Idle after reset
    repeat (20) cyc(0, 0, 0);

    // Start at div 2: rise at E0+2, then 10 periods of 4
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("first_low", {31'b0, bus.clk_slow}, 32'd0);
    cyc(1, 0, 0);
    chk("first_rise", {31'b0, bus.clk_slow}, 32'd1);
    ticks = 1;
    for (int i = 0; i < 37; i++) begin cyc(1, 0, 0); ticks += bus.tick; end
    chk("tick_count_div2", 32'(ticks), 32'd10);

    // Reconfigure to 3 during a high phase
    wait_rise(1);
    cyc(1, 1, 3);
    chk("ready_drop", {31'b0, bus.cfg_ready}, 32'd0);
    meas(0, 1, len);
    chk("low_len_div3", 32'(len), 32'd3);
    meas(1, 1, len);
    chk("high_len_div3", 32'(len), 32'd3);

    // Illegal word while running
    cyc(1, 1, 0);
    chk("err_pulse", {31'b0, bus.cfg_err}, 32'd1);
    cyc(1, 0, 0);
    chk("err_clear", {31'b0, bus.cfg_err}, 32'd0);
    chk("div_kept", {16'b0, bus.cur_div}, 32'd3);

    // Switch to 4, then stop one cycle after a rise
    cyc(1, 1, 4);
    repeat (8) cyc(1, 0, 0);
    wait_rise(1);
    chk("div4_applied", {16'b0, bus.cur_div}, 32'd4);
    meas(1, 0, len);
    chk("stop_high_len", 32'(len), 32'd4);
    chk("stop_busy", {31'b0, bus.busy}, 32'd0);
    repeat (5) cyc(0, 0, 0);

    // Re-raise en during STOP: waveform continues unbroken
    cyc(1, 0, 0);
    wait_rise(1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("in_stop", {31'b0, bus.busy}, 32'd1);
    cyc(1, 0, 0);
    meas(0, 1, len);
    chk("resume_low_len", 32'(len), 32'd4);

    // Async reset mid-high with a pending word
    wait_rise(1);
    cyc(1, 1, 7);
    chk("pend_set", {31'b0, bus.cfg_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_clk_slow", {31'b0, bus.clk_slow}, 32'd0);
    chk("rst_cur_div", {16'b0, bus.cur_div}, 32'd2);
    chk("rst_ready", {31'b0, bus.cfg_ready}, 32'd1);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    bus.en = 0; bus.cfg_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin cyc(0, 0, 0); ticks += bus.tick; end
    chk("no_tick_idle", 32'(ticks), 32'd0);

    // div 1 programmed while idle: period 2
    cyc(0, 1, 1);
    chk("idle_cfg", {16'b0, bus.cur_div}, 32'd1);
    cyc(1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin cyc(1, 0, 0); ticks += bus.tick; end
    chk("tick_count_div1", 32'(ticks), 32'd5);

    // Randomized traffic
    ren = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ren = !ren;
      r = $urandom_range(0, 5);
      cyc(ren, ($urandom_range(0, 3) == 0), r);
    end
    repeat (20) cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
